// File: rtl/minesweeper_pkg.sv
// Shared types for the minesweeper game sequencer: command opcodes, per-cell
// visibility states, game status codes and the mine marker value.
package minesweeper_pkg;

    typedef enum logic [1:0] {
        NEW_GAME = 2'd0,
        OPEN     = 2'd1,
        FLAG     = 2'd2
    } cmd_op_t;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        REVEALED = 2'd1,
        FLAGGED  = 2'd2
    } cell_state_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILLING = 3'd1,
        ST_PLAY    = 3'd2,
        ST_BUSY    = 3'd3,
        ST_WON     = 3'd4,
        ST_LOST    = 3'd5
    } game_status_t;

    localparam logic [3:0] MINE_VALUE = 4'd9;

endpackage

// File: rtl/neighbour_zero_check.sv
// Combinational OR of the zero-map bits of the up-to-8 neighbours of (x, y),
// restricted to the active field; coordinates never wrap at the edges.
module neighbour_zero_check #(
    parameter int MAX_CELL_WIDTH  = 30,
    parameter int MAX_CELL_HEIGHT = 16,
    localparam int CELL_X_WIDTH   = $clog2(MAX_CELL_WIDTH),
    localparam int CELL_Y_WIDTH   = $clog2(MAX_CELL_HEIGHT)
) (
    input  logic [MAX_CELL_HEIGHT-1:0][MAX_CELL_WIDTH-1:0] zero_map,
    input  logic [CELL_X_WIDTH-1:0]                        x,
    input  logic [CELL_Y_WIDTH-1:0]                        y,
    input  logic [CELL_X_WIDTH-1:0]                        width,
    input  logic [CELL_Y_WIDTH-1:0]                        height,
    output logic                                           any_zero
);

    always_comb begin
        any_zero = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                // Signed offsets so that x-1 at column 0 falls below zero instead of wrapping.
                if (!(dx == 0 && dy == 0)
                    && (int'(x) + dx >= 0) && (int'(x) + dx < int'(width))
                    && (int'(x) + dx < MAX_CELL_WIDTH)
                    && (int'(y) + dy >= 0) && (int'(y) + dy < int'(height))
                    && (int'(y) + dy < MAX_CELL_HEIGHT)
                    && zero_map[CELL_Y_WIDTH'(int'(y) + dy)][CELL_X_WIDTH'(int'(x) + dx)]) begin
                    any_zero = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/minesweeper_game_ctrl.sv
// Minesweeper game sequencer: command handling, filler handshake, per-cell
// visibility map and raster-sweep flood reveal of zero-valued regions.
module minesweeper_game_ctrl
    import minesweeper_pkg::*;
#(
    parameter int MAX_CELL_WIDTH  = 30,
    parameter int MAX_CELL_HEIGHT = 16,
    localparam int MINES_COUNT_W  = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT/4),
    localparam int CELL_X_WIDTH   = $clog2(MAX_CELL_WIDTH),
    localparam int CELL_Y_WIDTH   = $clog2(MAX_CELL_HEIGHT),
    localparam int CNT_W          = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  cmd_op_t                  cmd_op_i,
    input  logic [CELL_X_WIDTH-1:0]  cmd_x_i,
    input  logic [CELL_Y_WIDTH-1:0]  cmd_y_i,
    input  logic [CELL_X_WIDTH-1:0]  cfg_width_i,
    input  logic [CELL_Y_WIDTH-1:0]  cfg_height_i,
    input  logic [MINES_COUNT_W-1:0] cfg_mines_i,
    output logic                     fill_start_o,
    input  logic                     fill_finished_i,
    output logic [CELL_X_WIDTH-1:0]  field_width_o,
    output logic [CELL_Y_WIDTH-1:0]  field_height_o,
    output logic [MINES_COUNT_W-1:0] mines_count_o,
    output logic [CELL_X_WIDTH-1:0]  rd_x_o,
    output logic [CELL_Y_WIDTH-1:0]  rd_y_o,
    input  logic [3:0]               rd_value_i,
    input  logic [CELL_X_WIDTH-1:0]  disp_x_i,
    input  logic [CELL_Y_WIDTH-1:0]  disp_y_i,
    output cell_state_t              disp_state_o,
    output game_status_t             status_o,
    output logic [CNT_W-1:0]         revealed_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL_WAIT, S_PLAY, S_READ_CELL, S_SWEEP, S_CHECK, S_WON, S_LOST
    } state_t;

    state_t      state, state_next;
    cell_state_t cells [MAX_CELL_HEIGHT][MAX_CELL_WIDTH];
    logic [MAX_CELL_HEIGHT-1:0][MAX_CELL_WIDTH-1:0] zero_map;
    logic        pass_changed;

    logic        cmd_fire, new_hit, open_hit, flag_hit;
    logic        nbr_zero, scan_hit, scan_last, read_is_mine, read_is_zero;
    cell_state_t cmd_cell, scan_cell;
    logic [CNT_W-1:0] safe_cells;

    function automatic logic in_field(input logic [CELL_X_WIDTH-1:0] cx,
                                      input logic [CELL_Y_WIDTH-1:0] cy);
        return (cx < field_width_o) && (cy < field_height_o)
            && (int'(cx) < MAX_CELL_WIDTH) && (int'(cy) < MAX_CELL_HEIGHT);
    endfunction

    function automatic cell_state_t cell_at(input logic [CELL_X_WIDTH-1:0] cx,
                                            input logic [CELL_Y_WIDTH-1:0] cy);
        if ((int'(cx) < MAX_CELL_WIDTH) && (int'(cy) < MAX_CELL_HEIGHT))
            return cells[cy][cx];
        return HIDDEN;
    endfunction

    neighbour_zero_check #(
        .MAX_CELL_WIDTH (MAX_CELL_WIDTH),
        .MAX_CELL_HEIGHT(MAX_CELL_HEIGHT)
    ) u_nbr (
        .zero_map(zero_map),
        .x       (rd_x_o),
        .y       (rd_y_o),
        .width   (field_width_o),
        .height  (field_height_o),
        .any_zero(nbr_zero)
    );

    assign cmd_ready_o  = (state == S_IDLE) || (state == S_PLAY) || (state == S_WON) || (state == S_LOST);
    assign cmd_fire     = cmd_valid_i && cmd_ready_o;
    assign cmd_cell     = cell_at(cmd_x_i, cmd_y_i);
    assign scan_cell    = cell_at(rd_x_o, rd_y_o);
    assign new_hit      = cmd_fire && (cmd_op_i == NEW_GAME);
    assign open_hit     = cmd_fire && (state == S_PLAY) && (cmd_op_i == OPEN)
                          && in_field(cmd_x_i, cmd_y_i) && (cmd_cell == HIDDEN);
    assign flag_hit     = cmd_fire && (state == S_PLAY) && (cmd_op_i == FLAG)
                          && in_field(cmd_x_i, cmd_y_i) && (cmd_cell != REVEALED);
    assign read_is_mine = (rd_value_i == MINE_VALUE);
    assign read_is_zero = (rd_value_i == 4'd0);
    // The mine guard is redundant on a consistent field but keeps a bad filler from ending the game silently.
    assign scan_hit     = (state == S_SWEEP) && (scan_cell == HIDDEN) && nbr_zero && !read_is_mine;
    assign scan_last    = (rd_x_o == field_width_o - 1'b1) && (rd_y_o == field_height_o - 1'b1);
    assign safe_cells   = CNT_W'(field_width_o) * CNT_W'(field_height_o) - CNT_W'(mines_count_o);

    always_comb disp_state_o = cell_at(disp_x_i, disp_y_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        status_o   = ST_IDLE;
        case (state)
            S_IDLE: begin
                status_o = ST_IDLE;
                if (new_hit) state_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                status_o = ST_FILLING;
                if (fill_finished_i) state_next = S_PLAY;
            end
            S_PLAY: begin
                status_o = ST_PLAY;
                if (new_hit)       state_next = S_FILL_WAIT;
                else if (open_hit) state_next = S_READ_CELL;
            end
            S_READ_CELL: begin
                status_o = ST_BUSY;
                if (read_is_mine)      state_next = S_LOST;
                else if (read_is_zero) state_next = S_SWEEP;
                else                   state_next = S_CHECK;
            end
            S_SWEEP: begin
                status_o = ST_BUSY;
                if (scan_last && !pass_changed && !scan_hit) state_next = S_CHECK;
            end
            S_CHECK: begin
                status_o   = ST_BUSY;
                state_next = (revealed_cnt_o == safe_cells) ? S_WON : S_PLAY;
            end
            S_WON: begin
                status_o = ST_WON;
                if (new_hit) state_next = S_FILL_WAIT;
            end
            S_LOST: begin
                status_o = ST_LOST;
                if (new_hit) state_next = S_FILL_WAIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int yy = 0; yy < MAX_CELL_HEIGHT; yy++)
                for (int xx = 0; xx < MAX_CELL_WIDTH; xx++)
                    cells[CELL_Y_WIDTH'(yy)][CELL_X_WIDTH'(xx)] <= HIDDEN;
            zero_map       <= '0;
            pass_changed   <= 1'b0;
            revealed_cnt_o <= '0;
            fill_start_o   <= 1'b0;
            field_width_o  <= '0;
            field_height_o <= '0;
            mines_count_o  <= '0;
            rd_x_o         <= '0;
            rd_y_o         <= '0;
        end else begin
            fill_start_o <= new_hit;
            if (new_hit) begin
                for (int yy = 0; yy < MAX_CELL_HEIGHT; yy++)
                    for (int xx = 0; xx < MAX_CELL_WIDTH; xx++)
                        cells[CELL_Y_WIDTH'(yy)][CELL_X_WIDTH'(xx)] <= HIDDEN;
                zero_map       <= '0;
                pass_changed   <= 1'b0;
                revealed_cnt_o <= '0;
                field_width_o  <= cfg_width_i;
                field_height_o <= cfg_height_i;
                mines_count_o  <= cfg_mines_i;
            end
            if (flag_hit)
                cells[cmd_y_i][cmd_x_i] <= (cmd_cell == FLAGGED) ? HIDDEN : FLAGGED;
            if (open_hit) begin
                rd_x_o <= cmd_x_i;
                rd_y_o <= cmd_y_i;
            end
            if (state == S_READ_CELL) begin
                cells[rd_y_o][rd_x_o] <= REVEALED;
                if (!read_is_mine) revealed_cnt_o <= revealed_cnt_o + 1'b1;
                if (read_is_zero) begin
                    zero_map[rd_y_o][rd_x_o] <= 1'b1;
                    rd_x_o       <= '0;
                    rd_y_o       <= '0;
                    pass_changed <= 1'b0;
                end
            end
            // One cell per cycle, y-major; a pass that revealed anything triggers another pass.
            if (state == S_SWEEP) begin
                if (scan_hit) begin
                    cells[rd_y_o][rd_x_o] <= REVEALED;
                    revealed_cnt_o        <= revealed_cnt_o + 1'b1;
                    if (read_is_zero) zero_map[rd_y_o][rd_x_o] <= 1'b1;
                end
                if (scan_last) begin
                    rd_x_o       <= '0;
                    rd_y_o       <= '0;
                    pass_changed <= 1'b0;
                end else begin
                    pass_changed <= pass_changed | scan_hit;
                    if (rd_x_o == field_width_o - 1'b1) begin
                        rd_x_o <= '0;
                        rd_y_o <= rd_y_o + 1'b1;
                    end else begin
                        rd_x_o <= rd_x_o + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// Scoreboard bench for minesweeper_game_ctrl: a bench-side filler/field model
// supplies cell values; expectations are queued with each command and popped afterwards.
module tb_minesweeper_game_ctrl;
    import minesweeper_pkg::*;

    localparam int MAXW = 30;
    localparam int MAXH = 16;
    localparam int XW   = $clog2(MAXW);
    localparam int YW   = $clog2(MAXH);
    localparam int MW   = $clog2(MAXW*MAXH/4);
    localparam int CW   = $clog2(MAXW*MAXH+1);

    localparam int K_STATUS = 0;
    localparam int K_CNT    = 1;
    localparam int K_CELL   = 2;
    localparam int K_READY  = 3;
    localparam int K_FILL   = 4;
    localparam int K_WIDTH  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    cmd_op_t       cmd_op_i = NEW_GAME;
    logic [XW-1:0] cmd_x_i = '0;
    logic [YW-1:0] cmd_y_i = '0;
    logic [XW-1:0] cfg_width_i = '0;
    logic [YW-1:0] cfg_height_i = '0;
    logic [MW-1:0] cfg_mines_i = '0;
    logic          fill_start_o;
    logic          fill_finished_i = 1'b0;
    logic [XW-1:0] field_width_o;
    logic [YW-1:0] field_height_o;
    logic [MW-1:0] mines_count_o;
    logic [XW-1:0] rd_x_o;
    logic [YW-1:0] rd_y_o;
    logic [3:0]    rd_value_i;
    logic [XW-1:0] disp_x_i = '0;
    logic [YW-1:0] disp_y_i = '0;
    cell_state_t   disp_state_o;
    game_status_t  status_o;
    logic [CW-1:0] revealed_cnt_o;

    minesweeper_game_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_x_i        (cmd_x_i),
        .cmd_y_i        (cmd_y_i),
        .cfg_width_i    (cfg_width_i),
        .cfg_height_i   (cfg_height_i),
        .cfg_mines_i    (cfg_mines_i),
        .fill_start_o   (fill_start_o),
        .fill_finished_i(fill_finished_i),
        .field_width_o  (field_width_o),
        .field_height_o (field_height_o),
        .mines_count_o  (mines_count_o),
        .rd_x_o         (rd_x_o),
        .rd_y_o         (rd_y_o),
        .rd_value_i     (rd_value_i),
        .disp_x_i       (disp_x_i),
        .disp_y_i       (disp_y_i),
        .disp_state_o   (disp_state_o),
        .status_o       (status_o),
        .revealed_cnt_o (revealed_cnt_o)
    );

    always #5 clk = ~clk;

    logic mine_map [MAXH][MAXW];
    int   cur_w = 0;
    int   cur_h = 0;

    function automatic logic [3:0] field_value(input int x, input int y);
        int n = 0;
        if (x >= cur_w || y >= cur_h || x >= MAXW || y >= MAXH) return 4'd0;
        if (mine_map[YW'(y)][XW'(x)]) return MINE_VALUE;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < cur_w
                    && y + dy >= 0 && y + dy < cur_h
                    && mine_map[YW'(y + dy)][XW'(x + dx)])
                    n++;
            end
        end
        return 4'(n);
    endfunction

    always_comb rd_value_i = field_value(int'(rd_x_o), int'(rd_y_o));

    int    checks = 0;
    int    errors = 0;
    string tag_q[$];
    int    kind_q[$];
    int    x_q[$];
    int    y_q[$];
    int    exp_q[$];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int kind, input int x, input int y, input int exp);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        x_q.push_back(x);
        y_q.push_back(y);
        exp_q.push_back(exp);
    endtask

    task automatic drain_sb();
        string tag;
        int    kind, x, y, exp, got;
        while (tag_q.size() > 0) begin
            tag  = tag_q.pop_front();
            kind = kind_q.pop_front();
            x    = x_q.pop_front();
            y    = y_q.pop_front();
            exp  = exp_q.pop_front();
            case (kind)
                K_STATUS: got = int'(status_o);
                K_CNT:    got = int'(revealed_cnt_o);
                K_CELL: begin
                    disp_x_i = XW'(x);
                    disp_y_i = YW'(y);
                    #1;
                    got = int'(disp_state_o);
                end
                K_READY:  got = int'(cmd_ready_o);
                K_FILL:   got = int'(fill_start_o);
                K_WIDTH:  got = int'(field_width_o);
                default:  got = -1;
            endcase
            check_val(tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) check_val("ready_timeout", 0, 1);
    endtask

    task automatic issue(input cmd_op_t op, input int x, input int y);
        @(negedge clk);
        wait_ready();
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_x_i     = XW'(x);
        cmd_y_i     = YW'(y);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_cmd(input cmd_op_t op, input int x, input int y);
        issue(op, x, y);
        @(negedge clk);
        wait_ready();
        drain_sb();
    endtask

    task automatic clear_mines();
        for (int yy = 0; yy < MAXH; yy++)
            for (int xx = 0; xx < MAXW; xx++)
                mine_map[YW'(yy)][XW'(xx)] = 1'b0;
    endtask

    task automatic set_mine(input int x, input int y);
        mine_map[YW'(y)][XW'(x)] = 1'b1;
    endtask

    task automatic new_game(input int w, input int h, input int m);
        cur_w        = w;
        cur_h        = h;
        cfg_width_i  = XW'(w);
        cfg_height_i = YW'(h);
        cfg_mines_i  = MW'(m);
        push_exp("fill_pulse", K_FILL, 0, 0, 1);
        push_exp("fill_status", K_STATUS, 0, 0, int'(ST_FILLING));
        push_exp("fill_width", K_WIDTH, 0, 0, w);
        push_exp("fill_busy", K_READY, 0, 0, 0);
        issue(NEW_GAME, 0, 0);
        drain_sb();
        @(posedge clk);
        #1;
        push_exp("fill_pulse_end", K_FILL, 0, 0, 0);
        push_exp("fill_waiting", K_STATUS, 0, 0, int'(ST_FILLING));
        drain_sb();
        repeat (3) @(negedge clk);
        fill_finished_i = 1'b1;
        @(negedge clk);
        fill_finished_i = 1'b0;
        wait_ready();
        push_exp("play_status", K_STATUS, 0, 0, int'(ST_PLAY));
        push_exp("play_ready", K_READY, 0, 0, 1);
        push_exp("play_cnt", K_CNT, 0, 0, 0);
        push_exp("play_cell00", K_CELL, 0, 0, int'(HIDDEN));
        drain_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mines();
        repeat (2) @(negedge clk);
        push_exp("rst_status", K_STATUS, 0, 0, int'(ST_IDLE));
        push_exp("rst_cnt", K_CNT, 0, 0, 0);
        push_exp("rst_fill", K_FILL, 0, 0, 0);
        push_exp("rst_ready", K_READY, 0, 0, 1);
        push_exp("rst_cell", K_CELL, 3, 2, int'(HIDDEN));
        drain_sb();
        @(negedge clk);
        rst = 1'b0;

        // 8x8, 10 mines: three mines above (1,1) give it the value 3.
        set_mine(0, 0); set_mine(1, 0); set_mine(2, 0); set_mine(7, 7); set_mine(6, 7);
        set_mine(5, 7); set_mine(7, 6); set_mine(0, 7); set_mine(7, 0); set_mine(4, 4);
        new_game(8, 8, 10);
        push_exp("open3_cell", K_CELL, 1, 1, int'(REVEALED));
        push_exp("open3_nbr", K_CELL, 2, 1, int'(HIDDEN));
        push_exp("open3_cnt", K_CNT, 0, 0, 1);
        push_exp("open3_status", K_STATUS, 0, 0, int'(ST_PLAY));
        run_cmd(OPEN, 1, 1);
        push_exp("flag_set", K_CELL, 5, 5, int'(FLAGGED));
        run_cmd(FLAG, 5, 5);
        push_exp("open_flagged", K_CELL, 5, 5, int'(FLAGGED));
        push_exp("open_flagged_cnt", K_CNT, 0, 0, 1);
        run_cmd(OPEN, 5, 5);
        push_exp("flag_clear", K_CELL, 5, 5, int'(HIDDEN));
        run_cmd(FLAG, 5, 5);
        push_exp("flag_revealed", K_CELL, 1, 1, int'(REVEALED));
        run_cmd(FLAG, 1, 1);
        push_exp("mine_status", K_STATUS, 0, 0, int'(ST_LOST));
        push_exp("mine_cell", K_CELL, 0, 0, int'(REVEALED));
        push_exp("mine_cnt", K_CNT, 0, 0, 1);
        run_cmd(OPEN, 0, 0);
        push_exp("lost_open_status", K_STATUS, 0, 0, int'(ST_LOST));
        push_exp("lost_open_cell", K_CELL, 5, 5, int'(HIDDEN));
        push_exp("lost_open_cnt", K_CNT, 0, 0, 1);
        run_cmd(OPEN, 5, 5);

        // 4x4 with one mine at (3,3): interrupt the flood with reset, then replay to a win.
        clear_mines();
        set_mine(3, 3);
        new_game(4, 4, 1);
        issue(OPEN, 0, 0);
        repeat (4) @(negedge clk);
        push_exp("sweep_busy", K_STATUS, 0, 0, int'(ST_BUSY));
        push_exp("sweep_cell00", K_CELL, 0, 0, int'(REVEALED));
        drain_sb();
        rst = 1'b1;
        #1;
        push_exp("midrst_status", K_STATUS, 0, 0, int'(ST_IDLE));
        push_exp("midrst_cnt", K_CNT, 0, 0, 0);
        push_exp("midrst_cell00", K_CELL, 0, 0, int'(HIDDEN));
        push_exp("midrst_cell10", K_CELL, 1, 0, int'(HIDDEN));
        drain_sb();
        @(negedge clk);
        rst = 1'b0;
        new_game(4, 4, 1);
        push_exp("flood_cnt", K_CNT, 0, 0, 15);
        push_exp("flood_status", K_STATUS, 0, 0, int'(ST_WON));
        push_exp("flood_cell22", K_CELL, 2, 2, int'(REVEALED));
        push_exp("flood_cell32", K_CELL, 3, 2, int'(REVEALED));
        push_exp("flood_mine", K_CELL, 3, 3, int'(HIDDEN));
        run_cmd(OPEN, 0, 0);

        // 6x6 with a wall of mines in column 3: the flood must stop at column 2.
        clear_mines();
        for (int yy = 0; yy < 6; yy++) set_mine(3, yy);
        new_game(6, 6, 6);
        push_exp("oor_cnt", K_CNT, 0, 0, 0);
        push_exp("oor_status", K_STATUS, 0, 0, int'(ST_PLAY));
        run_cmd(OPEN, 8, 2);
        push_exp("corner_cnt", K_CNT, 0, 0, 18);
        push_exp("corner_status", K_STATUS, 0, 0, int'(ST_PLAY));
        push_exp("corner_cell25", K_CELL, 2, 5, int'(REVEALED));
        push_exp("corner_wall", K_CELL, 3, 0, int'(HIDDEN));
        push_exp("corner_beyond", K_CELL, 4, 0, int'(HIDDEN));
        push_exp("corner_x_oor", K_CELL, 6, 0, int'(HIDDEN));
        push_exp("corner_y_oor", K_CELL, 0, 6, int'(HIDDEN));
        run_cmd(OPEN, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
